// File: rtl/reloj_pio_gen.sv
// Avalon-MM GPIO: per-bit direction, atomic set/clear, synchronised inputs, edge capture + maskable irq.
// Latency: zero-wait-state reads; writes land on the next clk edge; input edges set capture 2 edges after sync1.
// Backpressure: none; the slave always accepts and never stalls the bus.
//
// Ports:
//   clk, reset_n                       clock and asynchronous active-low reset
//   address, chipselect, write_n       Avalon-MM slave control (word addressed)
//   writedata / readdata               32-bit data; bits above WIDTH-1 ignored / read as 0
//   in_port                            external inputs, asynchronous to clk
//   out_port                           output data register, driven regardless of direction
//   irq                                level interrupt, |(edge_capture & irq_mask)
module reloj_pio_gen #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] DIR_RESET = '0,
  parameter logic [WIDTH-1:0] OUT_RESET = '0,
  parameter int               EDGE_TYPE = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic             irq
);

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_DIR      = 3'd1;
  localparam logic [2:0] ADDR_MASK     = 3'd2;
  localparam logic [2:0] ADDR_EDGE     = 3'd3;
  localparam logic [2:0] ADDR_OUTSET   = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] direction;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] prev;

  logic             wr_en;
  logic [WIDTH-1:0] wdat;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] w1c;
  logic [WIDTH-1:0] rd_val;

  assign wr_en = chipselect & ~write_n;
  assign wdat  = writedata[WIDTH-1:0];

  // Edge flavour is fixed at elaboration; every bit is watched regardless
  // of direction, software filters with irq_mask.
  always_comb begin
    edge_det = '0;
    if (EDGE_TYPE == 0)      edge_det = sync2 & ~prev;
    else if (EDGE_TYPE == 1) edge_det = ~sync2 & prev;
    else                     edge_det = sync2 ^ prev;
  end

  assign w1c = (wr_en && address == ADDR_EDGE) ? wdat : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out     <= OUT_RESET;
      direction    <= DIR_RESET;
      irq_mask     <= '0;
      edge_capture <= '0;
      sync1        <= '0;
      sync2        <= '0;
      prev         <= '0;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
      prev  <= sync2;
      // A fresh edge beats a simultaneous clear so no event is ever lost.
      edge_capture <= (edge_capture & ~w1c) | edge_det;
      if (wr_en) begin
        case (address)
          ADDR_DATA:     data_out  <= wdat;
          ADDR_DIR:      direction <= wdat;
          ADDR_MASK:     irq_mask  <= wdat;
          ADDR_OUTSET:   data_out  <= data_out | wdat;
          ADDR_OUTCLEAR: data_out  <= data_out & ~wdat;
          default:       ;
        endcase
      end
    end
  end

  always_comb begin
    rd_val = '0;
    case (address)
      ADDR_DATA: rd_val = (sync2 & ~direction) | (data_out & direction);
      ADDR_DIR:  rd_val = direction;
      ADDR_MASK: rd_val = irq_mask;
      ADDR_EDGE: rd_val = edge_capture;
      default:   rd_val = '0;
    endcase
  end

  always_comb begin
    readdata              = '0;
    readdata[WIDTH-1:0]   = rd_val;
  end

  assign out_port = data_out;
  assign irq      = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_reloj_pio_gen.sv
module tb_reloj_pio_gen;

  logic        clk;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  in_port;
  logic [7:0]  out_port;
  logic        irq;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  reloj_pio_gen #(
    .WIDTH(8), .DIR_RESET(8'hFF), .OUT_RESET(8'h00), .EDGE_TYPE(0)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .in_port(in_port), .out_port(out_port), .irq(irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic expect_val(input string tag, input logic [31:0] val);
    exp_q.push_back(val);
    tag_q.push_back(tag);
  endtask

  task automatic check(input logic [31:0] obs);
    logic [31:0] e;
    string t;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty observed=%h", obs);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (obs === e) else begin
        n_fail++;
        $error("FAIL %s observed=%h expected=%h", t, obs, e);
      end
    end
  endtask

  // One-cycle bus write: driven after a falling edge, applied on the next rising edge.
  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] a, input string tag, input logic [31:0] val);
    expect_val(tag, val);
    chipselect = 1'b1; address = a;
    #1;
    check(readdata);
    chipselect = 1'b0;
  endtask

  task automatic wait_neg(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0; address = '0; chipselect = 1'b0; write_n = 1'b1;
    writedata = '0; in_port = '0;
    wait_neg(2);
    reset_n = 1'b1;
    wait_neg(1);

    // 1: reset state
    expect_val("rst_out_port", 32'h00); check({24'h0, out_port});
    expect_val("rst_irq", 32'h0);       check({31'h0, irq});
    bus_read(3'd1, "rst_dir", 32'h0000_00FF);

    // 2: data / outset / outclear
    bus_write(3'd0, 32'hA5); expect_val("data_a5", 32'hA5); check({24'h0, out_port});
    bus_write(3'd4, 32'h0F); expect_val("outset", 32'hAF);  check({24'h0, out_port});
    bus_write(3'd5, 32'h81); expect_val("outclr", 32'h2E);  check({24'h0, out_port});
    bus_read(3'd0, "rd_data_out", 32'h2E);
    bus_write(3'd4, 32'h00); bus_write(3'd5, 32'h00);
    expect_val("set_clr_zero", 32'h2E); check({24'h0, out_port});
    bus_read(3'd4, "rd_outset", 32'h0);
    // back-to-back writes, each applied in its own cycle
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b0; address = 3'd4; writedata = 32'h40;
    @(negedge clk);
    expect_val("b2b_first", 32'h6E); check({24'h0, out_port});
    address = 3'd5; writedata = 32'h40;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
    expect_val("b2b_second", 32'h2E); check({24'h0, out_port});

    // 3: inputs through the synchroniser
    bus_write(3'd1, 32'h00);
    @(negedge clk); in_port = 8'h03;
    @(posedge clk); #1;
    bus_read(3'd0, "sync_not_yet", 32'h00);
    @(posedge clk); @(posedge clk); #1;
    bus_read(3'd0, "sync_in", 32'h03);
    expect_val("out_unchanged", 32'h2E); check({24'h0, out_port});
    @(negedge clk);
    bus_read(3'd3, "cap_inputs", 32'h03);
    expect_val("irq_masked", 32'h0); check({31'h0, irq});

    // 4: rising capture on bit 0
    in_port = 8'h00; wait_neg(4);
    bus_read(3'd3, "fall_no_cap", 32'h03);
    bus_write(3'd3, 32'hFF);
    bus_read(3'd3, "w1c_all", 32'h00);
    bus_write(3'd2, 32'h01);
    @(negedge clk); in_port = 8'h01;
    @(posedge clk); #1;
    @(posedge clk); #1;
    expect_val("irq_early", 32'h0); check({31'h0, irq});
    @(posedge clk); #1;
    expect_val("irq_set", 32'h1); check({31'h0, irq});
    bus_read(3'd3, "cap_bit0", 32'h01);
    bus_write(3'd3, 32'h01);
    expect_val("irq_w1c", 32'h0); check({31'h0, irq});
    @(negedge clk); in_port = 8'h00; wait_neg(4);
    bus_read(3'd3, "fall_b0", 32'h00);

    // 5: mask-after-capture and set-beats-clear
    @(negedge clk); in_port = 8'h01; wait_neg(4);
    bus_write(3'd2, 32'h00);
    expect_val("irq_unmasked_off", 32'h0); check({31'h0, irq});
    bus_write(3'd2, 32'h01);
    expect_val("irq_unmask", 32'h1); check({31'h0, irq});
    in_port = 8'h00; wait_neg(4);
    in_port = 8'h01;
    @(negedge clk);
    bus_write(3'd3, 32'h01);
    bus_read(3'd3, "set_beats_clr", 32'h01);
    expect_val("irq_stays", 32'h1); check({31'h0, irq});

    // 6: async reset mid-write, reserved addresses
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b0; address = 3'd0; writedata = 32'h77;
    #2 reset_n = 1'b0;
    #1;
    expect_val("arst_out", 32'h00); check({24'h0, out_port});
    expect_val("arst_irq", 32'h0);  check({31'h0, irq});
    @(posedge clk); #1;
    expect_val("arst_abort", 32'h00); check({24'h0, out_port});
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; in_port = 8'h00;
    reset_n = 1'b1;
    bus_read(3'd3, "arst_cap", 32'h0);
    bus_write(3'd6, 32'hFFFF_FFFF);
    bus_write(3'd7, 32'hFFFF_FFFF);
    bus_read(3'd6, "rd_rsv6", 32'h0);
    bus_read(3'd7, "rd_rsv7", 32'h0);
    bus_read(3'd0, "rsv_data", 32'h0);
    bus_read(3'd1, "rsv_dir", 32'hFF);
    bus_read(3'd2, "rsv_mask", 32'h0);
    expect_val("rsv_out", 32'h0); check({24'h0, out_port});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
